// File: rtl/word_inv_aes.sv
// word_inv_aes: one AES inverse-cipher round on a 4-word state, streamed a column at a time.
module word_inv_aes (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_word,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [31:0]  out_word,
  output logic         out_valid,
  input  logic         out_ready
);
  typedef enum logic {LOAD, EMIT} state_t;
  localparam logic [2047:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  state_t        r_state, w_state_nxt;
  logic [1:0]    r_cnt;
  logic [31:0]   r_buf [4];
  logic [127:0]  r_key;
  logic          r_last;
  logic [31:0]   r_out;
  logic          w_acc, w_emit;
  logic [1:0]    w_col;
  logic [31:0]   w_src [4];
  logic [7:0]    w_s [4];
  logic [31:0]   w_res;

  function automatic logic [7:0] isb(input logic [7:0] x);
    return ISBOX[{~x, 3'b111} -: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // k selects which of b, 2b, 4b, 8b are summed (e.g. 4'he = 8b^4b^2b)
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (k[3] ? b8 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction

  assign w_acc     = (r_state == LOAD) && in_valid;
  assign w_emit    = (r_state == EMIT) && out_ready;
  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == EMIT);
  assign out_word  = r_out;

  // The column being registered is 0 on the final accept, otherwise the next one to emit
  always_comb begin
    w_col = (r_state == LOAD) ? 2'd0 : r_cnt + 2'd1;
    w_src = r_buf;
    if (w_acc) w_src[r_cnt] = in_word;
    for (int r = 0; r < 4; r++)
      w_s[r] = isb(w_src[w_col - 2'(r)][31-8*r -: 8]) ^ r_key[127-32*w_col-8*r -: 8];
    w_res = r_last ? {w_s[0], w_s[1], w_s[2], w_s[3]} :
      {gm(w_s[0], 4'he) ^ gm(w_s[1], 4'hb) ^ gm(w_s[2], 4'hd) ^ gm(w_s[3], 4'h9),
       gm(w_s[0], 4'h9) ^ gm(w_s[1], 4'he) ^ gm(w_s[2], 4'hb) ^ gm(w_s[3], 4'hd),
       gm(w_s[0], 4'hd) ^ gm(w_s[1], 4'h9) ^ gm(w_s[2], 4'he) ^ gm(w_s[3], 4'hb),
       gm(w_s[0], 4'hb) ^ gm(w_s[1], 4'hd) ^ gm(w_s[2], 4'h9) ^ gm(w_s[3], 4'he)};
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc && r_cnt == 2'd3) w_state_nxt = EMIT;
    else if (w_emit && r_cnt == 2'd3) w_state_nxt = LOAD;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= LOAD;
    else r_state <= w_state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_buf  <= '{default: 32'h0};
      r_key  <= 128'h0;
      r_last <= 1'b0;
      r_out  <= 32'h0;
    end else if (w_acc) begin
      r_buf[r_cnt] <= in_word;
      r_cnt        <= r_cnt + 2'd1;
      if (r_cnt == 2'd0) begin
        r_key  <= round_key;
        r_last <= last_round;
      end
      if (r_cnt == 2'd3) r_out <= w_res;
    end else if (w_emit) begin
      r_cnt <= r_cnt + 2'd1;
      if (r_cnt != 2'd3) r_out <= w_res;
    end
  end
endmodule

// File: tb/tb_word_inv_aes.sv
// tb_word_inv_aes: directed vectors with a queue scoreboard checked by an output monitor.
module tb_word_inv_aes;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] round_key;
  logic         last_round;
  logic [31:0]  out_word;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  exp_q [$];
  int           checks = 0;
  int           failures = 0;
  int           acc = 0;
  int           acc0;

  word_inv_aes dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .round_key(round_key), .last_round(last_round), .out_word(out_word),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) if (!rst && in_valid && in_ready) acc++;

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", out_word, 32'hxxxxxxxx);
      else chk("out_word", out_word, exp_q.pop_front());
    end

  task automatic send(input logic [31:0] w);
    in_word  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_in_ready", {31'h0, in_ready}, 32'h1);
  endtask

  task automatic blk(input logic [127:0] ws, input logic [127:0] es, input logic [127:0] key,
                     input logic last);
    for (int i = 0; i < 4; i++) exp_q.push_back(es[127-32*i -: 32]);
    round_key  = key;
    last_round = last;
    for (int i = 0; i < 4; i++) send(ws[127-32*i -: 32]);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_word = 32'h0; in_valid = 1'b0; round_key = 128'h0;
    last_round = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_word", out_word, 32'h0);
    rst = 1'b0;
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

    blk(128'h0, {4{32'h52525252}}, 128'h0, 1'b1);
    blk(128'h0, {4{32'h52525252}}, 128'h0, 1'b0);
    blk({4{32'h19e33265}}, {4{32'hdb135345}}, 128'h0, 1'b0);
    blk({4{32'h19e33265}}, {4{32'h24ecacba}}, {128{1'b1}}, 1'b0);
    blk({32'h63636363, 32'h637c6363, 32'h63636363, 32'h63636363},
        {32'h0, 32'h0, 32'h00010000, 32'h0}, 128'h0, 1'b1);

    // backpressure at k=1, with input traffic that must be ignored
    out_ready = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h00010000); exp_q.push_back(32'h0);
    round_key = 128'h0; last_round = 1'b1;
    send(32'h63636363); send(32'h637c6363); send(32'h63636363); send(32'h63636363);
    chk("bp_latency_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc0 = acc;
    in_valid = 1'b1; in_word = 32'hdeadbeef;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_word", out_word, 32'h0);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    chk("emit_ignores_input", acc, acc0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_k2", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    chk("bp_in_ready_k3", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    chk("bp_in_ready_back", {31'h0, in_ready}, 32'h1);

    // gapped input; key change after first accept must not take effect
    acc0 = acc;
    round_key = 128'h0; last_round = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hdb135345);
    for (int i = 0; i < 4; i++) begin
      send(32'h19e33265);
      if (i == 0) begin
        round_key = {128{1'b1}};
        last_round = 1'b1;
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("gap_latency_valid", {31'h0, out_valid}, 32'h1);
    chk("gap_accepts", acc - acc0, 4);
    wait_idle();

    // reset after two accepts discards the partial block
    round_key = 128'h0; last_round = 1'b1;
    send(32'h63636363); send(32'h637c6363);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_word", out_word, 32'h0);
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_out_word_clk", out_word, 32'h0);
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    blk(128'h0, {4{32'h52525252}}, 128'h0, 1'b1);

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/word_inv_aes.md
WORD_INV_AES -- requirements
Module: word_inv_aes

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32-bit words and 4 words per 128-bit state.
REQ-002 Port list:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_word  in  32  one state column; [31:24] = row 0 … [7:0] = row 3.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts in_word this cycle.
- round_key  in  128  round key; [127:96] = key word for column 0 … [31:0] = column 3.
- last_round  in  1  high = final inverse round (skip InvMixColumns).
- out_word  out  32  result column, same byte order as in_word.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  downstream accepts out_word this cycle.

Function
REQ-003 The block SHALL perform one AES inverse-cipher round on a 4-word state, in this order: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last_round was sampled high.
REQ-004 The FSM SHALL have two states: LOAD and EMIT. Each state has a 2-bit word counter.
REQ-005 In LOAD, in_ready SHALL be 1 and out_valid SHALL be 0.
- An input is accepted when in_valid && in_ready.
- Accepted words fill buffer columns 0,1,2,3 in order; the counter increments per accept.
REQ-006 On the accept with counter 0, round_key and last_round SHALL be registered; they stay fixed for the rest of the block.
REQ-007 On the accept with counter 3, the FSM SHALL go to EMIT with the output counter at 0, and out_word SHALL be registered with result column 0.
- out_valid is therefore high in the cycle after the 4th accept (latency 1 cycle).
REQ-008 In EMIT, in_ready SHALL be 0 and out_valid SHALL be 1.
- out_word holds result column k.
- out_word and k stay stable while out_ready is low.
REQ-009 On out_valid && out_ready with k<3, the block SHALL increment k and register result column k+1.
- With k=3, the FSM SHALL return to LOAD with both counters at 0.
- in_ready is then 1 in the next cycle, so there is no back-to-back overlap between blocks.
REQ-010 InvShiftRows SHALL be: result column c, row r = buffer column (c−r) mod 4, row r.
REQ-011 InvSubBytes SHALL use the FIPS-197 inverse S-box (e.g. 0x00→0x52, 0x63→0x00, 0x7c→0x01).
REQ-012 AddRoundKey SHALL XOR column c with the registered key word for column c.
REQ-013 InvMixColumns SHALL multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 with coefficients {0e,0b,0d,09}, rotated per row; all results are exactly 8 bits per byte.
REQ-014 Changes to round_key or last_round after the first accept SHALL have no effect until the next block's first accept.
REQ-015 Input handshakes SHALL be ignored in EMIT, and out_ready SHALL be ignored in LOAD.

Reset
REQ-016 While rst=1, regardless of clk, the block SHALL hold:
- state = LOAD, both counters = 0;
- out_valid = 0, out_word = 0x00000000;
- key register = 0, last_round register = 0;
- buffer = 0.
REQ-017 Reset asserted mid-LOAD or mid-EMIT SHALL discard the partial block; the first accept after deassertion is column 0.
REQ-018 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-019 Zero state: 4× in_word=0x00000000, key=0, last_round=1 -> out_word 0x52525252 ×4. Same with last_round=0 -> 0x52525252 ×4.
REQ-020 InvMixColumns: 4× 0x19e33265, key=0, last_round=0 -> 0xdb135345 ×4. With key all 0xffffffff -> 0x24ecacba ×4.
REQ-021 InvShiftRows: words 0x63636363, 0x637c6363, 0x63636363, 0x63636363 with last_round=1, key=0 -> outputs 0x00000000, 0x00000000, 0x00010000, 0x00000000.
REQ-022 Backpressure: hold out_ready=0 for 5 cycles at k=1 -> out_word stable and out_valid=1. in_ready stays 0 until 1 cycle after the 4th out handshake.
REQ-023 Gapped input: in_valid toggling 1/0 -> exactly 4 accepts, then out_valid in the next cycle. round_key changed after the first accept -> results use the originally sampled key.
REQ-024 Reset mid-operation: rst pulse after 2 accepts, then 4 fresh words -> outputs match the fresh block only; out_valid=0 and out_word=0 during reset.
